gray_updown_counter: RTL and testbench

Parametrised up/down Gray-code counter, successor to the fixed 3-bit structural Gray counter. Adds configurable width, count enable, direction control, synchronous parallel load, a registered binary-equivalent output and a registered wrap flag. Used as a pointer or sequence source wherever single-bit-change state is needed, such as FIFO pointers and rotary/position sequencing.

---
 rtl/gray_updown_counter.sv | 97 +++++++++
 tb/tb_gray_updown_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray-code counter with parallel load, registered binary mirror and wrap flag.
// Define GRAY_CNT_SATURATE_EN to hold at the end values (tc flags each refused step) instead of wrapping.
module gray_updown_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] bin,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic [WIDTH-1:0] bin_next_s;
    logic             tc_next_s;
    logic             at_max_s;
    logic             at_min_s;

    assign at_max_s = (bin_r == MAX);
    assign at_min_s = (bin_r == ZERO);

    // Next binary value and boundary flag; load outranks counting and always clears tc.
    always_comb begin
        bin_next_s = bin_r;
        tc_next_s  = 1'b0;
        if (load) begin
            bin_next_s = gray2bin(load_val);
        end else if (en) begin
            if (up) begin
`ifdef GRAY_CNT_SATURATE_EN
                if (at_max_s) begin
                    tc_next_s = 1'b1;
                end else begin
                    bin_next_s = bin_r + ONE;
                end
`else
                bin_next_s = bin_r + ONE;
                tc_next_s  = at_max_s;
`endif
            end else begin
`ifdef GRAY_CNT_SATURATE_EN
                if (at_min_s) begin
                    tc_next_s = 1'b1;
                end else begin
                    bin_next_s = bin_r - ONE;
                end
`else
                bin_next_s = bin_r - ONE;
                tc_next_s  = at_min_s;
`endif
            end
        end else begin
            bin_next_s = bin_r;
        end
    end

    // State registers; count takes the Gray form of the next value so it never decodes combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_r   <= ZERO;
            count_r <= ZERO;
            tc_r    <= 1'b0;
        end else begin
            bin_r   <= bin_next_s;
            count_r <= bin2gray(bin_next_s);
            tc_r    <= tc_next_s;
        end
    end

    assign count = count_r;
    assign bin   = bin_r;
    assign tc    = tc_r;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench for gray_updown_counter: three widths (3, 4, 5) share controls, one is checked per vector.
module tb_gray_updown_counter;

    typedef struct {
        int         sel;
        logic [4:0] c;
        logic [4:0] b;
        logic       t;
        logic       ob;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [4:0] load_val;
    logic [2:0] count3, bin3;
    logic [3:0] count4, bin4;
    logic [4:0] count5, bin5;
    logic       tc3, tc4, tc5;
    logic [4:0] cnt_a [3];
    logic [4:0] bin_a [3];
    logic       tc_a  [3];
    logic [4:0] prev_c [3];

    exp_t exp_q[$];
    bit   armed = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef GRAY_CNT_SATURATE_EN
    logic [4:0] g_su [10] = '{5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04, 5'h04, 5'h04, 5'h04};
    logic [4:0] b_su [10] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h07, 5'h07, 5'h07};
    logic [4:0] g_sd [9]  = '{5'h05, 5'h07, 5'h06, 5'h02, 5'h03, 5'h01, 5'h00, 5'h00, 5'h00};
    logic [4:0] b_sd [9]  = '{5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00, 5'h00, 5'h00};
`else
    logic [4:0] g_up [9] = '{5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04, 5'h00, 5'h01};
    logic [4:0] b_up [9] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h00, 5'h01};
`endif
    bit         rv_up [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0] rv_g  [8] = '{5'h02, 5'h03, 5'h02, 5'h03, 5'h01, 5'h03, 5'h01, 5'h03};
    logic [4:0] rv_b  [8] = '{5'h03, 5'h02, 5'h03, 5'h02, 5'h01, 5'h02, 5'h01, 5'h02};

    gray_updown_counter #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val[2:0]), .count(count3), .bin(bin3), .tc(tc3)
    );
    gray_updown_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val[3:0]), .count(count4), .bin(bin4), .tc(tc4)
    );
    gray_updown_counter #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count5), .bin(bin5), .tc(tc5)
    );

    assign cnt_a[0] = {2'b00, count3};
    assign cnt_a[1] = {1'b0, count4};
    assign cnt_a[2] = count5;
    assign bin_a[0] = {2'b00, bin3};
    assign bin_a[1] = {1'b0, bin4};
    assign bin_a[2] = bin5;
    assign tc_a[0]  = tc3;
    assign tc_a[1]  = tc4;
    assign tc_a[2]  = tc5;

    always #5 clk = ~clk;

    task automatic chk(input string what, input string tag, input logic [4:0] got, input logic [4:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s %s: got %b want %b", tag, what, got, want);
        end
    endtask

    task automatic step(input string tag, input int sel, input logic r, input logic e, input logic u,
                        input logic l, input logic [4:0] lv, input logic [4:0] ec, input logic [4:0] eb,
                        input logic et, input logic ob);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; up = u; load = l; load_val = lv;
        x.sel = sel; x.c = ec; x.b = eb; x.t = et; x.ob = ob; x.tag = tag;
        exp_q.push_back(x);
        armed = 1'b1;
    endtask

    // Drop reset between edges: one check right after assertion, one at the following edge.
    task automatic rst_drop(input string tag, input int sel);
        exp_t x;
        @(negedge clk);
        en = 1'b1; up = 1'b1; load = 1'b0;
        #2;
        x.sel = sel; x.c = 5'h00; x.b = 5'h00; x.t = 1'b0; x.ob = 1'b0; x.tag = tag;
        exp_q.push_back(x);
        x.ob = 1'b1; x.tag = {tag, "_edge"};
        exp_q.push_back(x);
        rst = 1'b0;
    endtask

    // Monitor: every rising clock edge or reset assertion presents a new output to compare.
    initial begin
        exp_t e;
        for (int k = 0; k < 3; k++) prev_c[k] = 5'h00;
        forever begin
            @(posedge clk or negedge rst);
            if (armed) begin
                #1;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_underflow: got empty queue want an expectation");
                end else begin
                    e = exp_q.pop_front();
                    chk("count", e.tag, cnt_a[e.sel], e.c);
                    chk("bin", e.tag, bin_a[e.sel], e.b);
                    chk("tc", e.tag, {4'b0000, tc_a[e.sel]}, {4'b0000, e.t});
                    if (e.ob) begin
                        vectors++;
                        if ($countones(cnt_a[e.sel] ^ prev_c[e.sel]) > 1) begin
                            miscompares++;
                            $display("FAIL %s onebit: got %b after %b want at most one bit change",
                                     e.tag, cnt_a[e.sel], prev_c[e.sel]);
                        end
                    end
                end
                for (int k = 0; k < 3; k++) prev_c[k] = cnt_a[k];
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 5'h00;
        repeat (2) @(negedge clk);

        // Held in reset across an edge with en high: no step.
        step("rst_hold0", 0, 1'b0, 1'b1, 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, 1'b0, 1'b1);

`ifdef GRAY_CNT_SATURATE_EN
        for (int i = 0; i < 10; i++)
            step("sat_up_w3", 0, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, g_su[i], b_su[i], (i >= 7), 1'b1);
        for (int i = 0; i < 9; i++)
            step("sat_dn_w3", 0, 1'b1, 1'b1, 1'b0, 1'b0, 5'h00, g_sd[i], b_sd[i], (i >= 7), 1'b1);
        step("sat_hold", 0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, 1'b0, 1'b1);
`else
        for (int i = 0; i < 9; i++)
            step("up_w3", 0, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, g_up[i], b_up[i], (i == 7), 1'b1);
        step("dn_w3", 0, 1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, 1'b0, 1'b1);
        step("dn_wrap", 0, 1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 5'h04, 5'h07, 1'b1, 1'b1);
        step("dn_w3", 0, 1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 5'h05, 5'h06, 1'b0, 1'b1);
        step("dn_w3", 0, 1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 5'h07, 5'h05, 1'b0, 1'b1);
        step("hold_w3", 0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 5'h07, 5'h05, 1'b0, 1'b1);
`endif

        // Load with en high on the same edge: load wins.
        step("ld_w4", 1, 1'b1, 1'b1, 1'b1, 1'b1, 5'h0D, 5'h0D, 5'h09, 1'b0, 1'b0);
        step("ld_step", 1, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 5'h0F, 5'h0A, 1'b0, 1'b1);
        step("ld_max", 1, 1'b1, 1'b1, 1'b1, 1'b1, 5'h08, 5'h08, 5'h0F, 1'b0, 1'b0);
`ifdef GRAY_CNT_SATURATE_EN
        step("top_w4", 1, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 5'h08, 5'h0F, 1'b1, 1'b1);
`else
        step("top_w4", 1, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1);
`endif
        step("ld_noen", 1, 1'b1, 1'b0, 1'b0, 1'b1, 5'h06, 5'h06, 5'h04, 1'b0, 1'b0);

        // Direction reversal around count 011.
        step("ld_011", 0, 1'b1, 1'b0, 1'b1, 1'b1, 5'h03, 5'h03, 5'h02, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step("reverse", 0, 1'b1, 1'b1, rv_up[i], 1'b0, 5'h00, rv_g[i], rv_b[i], 1'b0, 1'b1);

        // Asynchronous reset mid-count on the 5-bit counter.
        step("ld_w5", 2, 1'b1, 1'b0, 1'b1, 1'b1, 5'h16, 5'h16, 5'h1B, 1'b0, 1'b0);
        rst_drop("async_rst", 2);
        step("rst_low", 2, 1'b0, 1'b1, 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, 1'b0, 1'b1);
        step("rst_rel", 2, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 5'h01, 5'h01, 1'b0, 1'b1);
        step("resume", 2, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 5'h03, 5'h02, 1'b0, 1'b1);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
